// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizing defaults and read-tag type for the register-file bank scheduler
package rf_pkg;

    localparam int NUM_OC     = 4;
    localparam int OCID_W     = 2;
    localparam int ROW_W      = 3;
    localparam int DATA_W     = 256;
    localparam int STARVE_MAX = 4;

    // Identifies an in-flight read: which collector asked and which row it gets back.
    typedef struct packed {
        logic [OCID_W-1:0] ocid;
        logic [ROW_W-1:0]  row;
    } rf_req_t;

endpackage

// File: rtl/rf_rr_arbiter.sv
// rtl/rf_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr_i
module rf_rr_arbiter #(
    parameter int NUM_OC = rf_pkg::NUM_OC,
    parameter int OCID_W = rf_pkg::OCID_W
) (
    input  logic [NUM_OC-1:0] req_i,
    input  logic [OCID_W-1:0] ptr_i,
    output logic [NUM_OC-1:0] gnt_o,
    output logic [OCID_W-1:0] idx_o,
    output logic              any_o
);
    import rf_pkg::*;

    always_comb begin
        logic              found;
        logic [OCID_W-1:0] cur;
        found = 1'b0;
        cur   = '0;
        idx_o = '0;
        // NUM_OC is a power of two, so the index add wraps naturally
        for (int i = 0; i < NUM_OC; i++) begin
            cur = ptr_i + OCID_W'(i);
            if (!found && req_i[cur]) begin
                found = 1'b1;
                idx_o = cur;
            end
        end
        any_o = |req_i;
        gnt_o = any_o ? (NUM_OC'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/rf_bank_scheduler.sv
// rtl/rf_bank_scheduler.sv - shares one RF bank port between collector reads and CDB writeback
module rf_bank_scheduler #(
    parameter int NUM_OC     = rf_pkg::NUM_OC,
    parameter int OCID_W     = rf_pkg::OCID_W,
    parameter int ROW_W      = rf_pkg::ROW_W,
    parameter int DATA_W     = rf_pkg::DATA_W,
    parameter int STARVE_MAX = rf_pkg::STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OC-1:0]        oc_req_valid,
    input  logic [NUM_OC*ROW_W-1:0]  oc_req_row,
    output logic [NUM_OC-1:0]        oc_req_ready,
    input  logic                     wb_valid,
    input  logic [ROW_W-1:0]         wb_row,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_ready,
    output logic                     rf_en,
    output logic                     rf_wr,
    output logic [ROW_W-1:0]         rf_addr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [DATA_W-1:0]        rf_rdata,
    output logic                     rd_valid,
    output logic [OCID_W-1:0]        rd_ocid,
    output logic [ROW_W-1:0]         rd_row,
    output logic [DATA_W-1:0]        rd_data
);
    import rf_pkg::*;

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic [OCID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              rd_valid_q;
    rf_req_t           tag_q, tag_d;

    logic [NUM_OC-1:0] cand_oh;
    logic [OCID_W-1:0] cand;
    logic              rd_pend;
    logic [ROW_W-1:0]  cand_row;
    logic              grant_rd, grant_wr;

    rf_rr_arbiter #(
        .NUM_OC (NUM_OC),
        .OCID_W (OCID_W)
    ) u_arb (
        .req_i (oc_req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (cand_oh),
        .idx_o (cand),
        .any_o (rd_pend)
    );

    assign cand_row = oc_req_row[cand*ROW_W +: ROW_W];

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (rd_pend && wb_valid) begin
            // A same-row write must land before the read so the collector sees fresh data
            if (cand_row == wb_row)          grant_wr = 1'b1;
            else if (starve_q == STARVE_LIM) grant_rd = 1'b1;
            else                             grant_wr = 1'b1;
        end else if (wb_valid) begin
            grant_wr = 1'b1;
        end else if (rd_pend) begin
            grant_rd = 1'b1;
        end

        oc_req_ready = grant_rd ? cand_oh : '0;
        wb_ready     = grant_wr;
        rf_en        = grant_rd | grant_wr;
        rf_wr        = grant_wr;
        rf_addr      = grant_wr ? wb_row : (grant_rd ? cand_row : '0);
        rf_wdata     = grant_wr ? wb_data : '0;

        rr_ptr_d = grant_rd ? cand + OCID_W'(1) : rr_ptr_q;

        if (grant_rd || !rd_pend)      starve_d = '0;
        else if (starve_q != STARVE_LIM) starve_d = starve_q + SC_W'(1);
        else                           starve_d = starve_q;

        tag_d = '{ocid: cand, row: cand_row};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            starve_q   <= '0;
            rd_valid_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            starve_q   <= starve_d;
            rd_valid_q <= grant_rd;
            if (grant_rd) tag_q <= tag_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_ocid  = tag_q.ocid;
    assign rd_row   = tag_q.row;
    assign rd_data  = rd_valid_q ? rf_rdata : '0;

endmodule

// File: tb/tb_rf_bank_scheduler.sv
// tb/tb_rf_bank_scheduler.sv - directed self-checking bench for rf_bank_scheduler
module tb_rf_bank_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   oc_req_valid;
    logic [11:0]  oc_req_row;
    logic [3:0]   oc_req_ready;
    logic         wb_valid;
    logic [2:0]   wb_row;
    logic [255:0] wb_data;
    logic         wb_ready;
    logic         rf_en;
    logic         rf_wr;
    logic [2:0]   rf_addr;
    logic [255:0] rf_wdata;
    logic [255:0] rf_rdata;
    logic         rd_valid;
    logic [1:0]   rd_ocid;
    logic [2:0]   rd_row;
    logic [255:0] rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_bank_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .oc_req_valid (oc_req_valid),
        .oc_req_row   (oc_req_row),
        .oc_req_ready (oc_req_ready),
        .wb_valid     (wb_valid),
        .wb_row       (wb_row),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .rf_en        (rf_en),
        .rf_wr        (rf_wr),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .rf_rdata     (rf_rdata),
        .rd_valid     (rd_valid),
        .rd_ocid      (rd_ocid),
        .rd_row       (rd_row),
        .rd_data      (rd_data)
    );

    // Unwritten rows read back as a per-row byte pattern: row r -> bytes 0xA6 + r
    function automatic logic [255:0] pat(input logic [2:0] r);
        logic [7:0] b;
        b = 8'hA6 + {5'd0, r};
        return {32{b}};
    endfunction

    logic [255:0] mem [8];
    logic [7:0]   wmask = 8'h00;

    always @(posedge clk) begin
        if (rf_en && rf_wr) begin
            mem[rf_addr]   <= rf_wdata;
            wmask[rf_addr] <= 1'b1;
        end
        if (rf_en && !rf_wr)
            rf_rdata <= wmask[rf_addr] ? mem[rf_addr] : pat(rf_addr);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        oc_req_valid = '0;
        oc_req_row   = '0;
        wb_valid     = 1'b0;
        wb_row       = '0;
        wb_data      = '0;

        // reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        smp();
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_wr", rf_wr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_oc_ready", oc_req_ready, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_ocid", rd_ocid, 0);

        // single read: OC2, row 5
        nx();
        oc_req_valid = 4'b0100;
        oc_req_row   = 12'd5 << 6;
        smp();
        chk("rd1_ready", oc_req_ready, 4'b0100);
        chk("rd1_wb_ready", wb_ready, 0);
        chk("rd1_rf_en", rf_en, 1);
        chk("rd1_rf_wr", rf_wr, 0);
        chk("rd1_rf_addr", rf_addr, 5);
        chk("rd1_rf_wdata", rf_wdata, 0);
        nx();
        oc_req_valid = '0;
        smp();
        chk("rd1_rd_valid", rd_valid, 1);
        chk("rd1_rd_ocid", rd_ocid, 2);
        chk("rd1_rd_row", rd_row, 5);
        chk("rd1_rd_data", rd_data, {32{8'hAB}});
        chk("rd1_idle_en", rf_en, 0);
        nx();
        smp();
        chk("rd1_after_valid", rd_valid, 0);
        chk("rd1_after_data", rd_data, 0);

        // round robin from a fresh pointer: OC i requests row i+1
        rst = 1'b0;
        nx();
        rst          = 1'b1;
        oc_req_valid = 4'hF;
        oc_req_row   = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int k = 0; k < 8; k++) begin
            smp();
            chk($sformatf("rr_ready_%0d", k), oc_req_ready, 4'b0001 << (k % 4));
            chk($sformatf("rr_addr_%0d", k), rf_addr, (k % 4) + 1);
            if (k > 0) begin
                chk($sformatf("rr_ocid_%0d", k), rd_ocid, (k - 1) % 4);
                chk($sformatf("rr_data_%0d", k), rd_data, pat(3'((k - 1) % 4 + 1)));
            end
            nx();
        end
        oc_req_valid = '0;
        smp();
        chk("rr_last_ocid", rd_ocid, 3);
        chk("rr_last_data", rd_data, pat(3'd4));

        // starvation limit: write to row 6 competes with OC1 row 2
        nx();
        wb_valid     = 1'b1;
        wb_row       = 3'd6;
        wb_data      = {32{8'hD6}};
        oc_req_valid = 4'b0010;
        oc_req_row   = 12'd2 << 3;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("stv_wb_ready_%0d", k), wb_ready, 1);
            chk($sformatf("stv_oc_ready_%0d", k), oc_req_ready, 0);
            chk($sformatf("stv_rf_wr_%0d", k), rf_wr, 1);
            chk($sformatf("stv_addr_%0d", k), rf_addr, 6);
            nx();
        end
        smp();
        chk("stv_force_ready", oc_req_ready, 4'b0010);
        chk("stv_force_wb_ready", wb_ready, 0);
        chk("stv_force_addr", rf_addr, 2);
        chk("stv_force_wr", rf_wr, 0);
        nx();
        smp();
        chk("stv_cleared_wb_ready", wb_ready, 1);
        chk("stv_cleared_oc_ready", oc_req_ready, 0);
        chk("stv_ret_valid", rd_valid, 1);
        chk("stv_ret_ocid", rd_ocid, 1);
        chk("stv_ret_data", rd_data, pat(3'd2));
        nx();
        wb_valid     = 1'b0;
        oc_req_valid = '0;

        // RAW protection at the starvation limit: OC0 row 3 vs writeback row 3
        nx();
        wb_valid     = 1'b1;
        wb_row       = 3'd6;
        oc_req_valid = 4'b0001;
        oc_req_row   = 12'd3;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("raw_pre_wb_%0d", k), wb_ready, 1);
            nx();
        end
        wb_row  = 3'd3;
        wb_data = {32{8'h11}};
        smp();
        chk("raw_wb_ready", wb_ready, 1);
        chk("raw_oc_ready", oc_req_ready, 0);
        chk("raw_addr", rf_addr, 3);
        chk("raw_wr", rf_wr, 1);
        chk("raw_wdata", rf_wdata, {32{8'h11}});
        nx();
        wb_valid = 1'b0;
        smp();
        chk("raw_rd_ready", oc_req_ready, 4'b0001);
        chk("raw_rd_addr", rf_addr, 3);
        chk("raw_rd_wr", rf_wr, 0);
        nx();
        oc_req_valid = '0;
        smp();
        chk("raw_ret_valid", rd_valid, 1);
        chk("raw_ret_ocid", rd_ocid, 0);
        chk("raw_ret_row", rd_row, 3);
        chk("raw_ret_data", rd_data, {32{8'h11}});

        // reset during a read return
        nx();
        oc_req_valid = 4'b0100;
        oc_req_row   = 12'd7 << 6;
        smp();
        chk("mid_grant", oc_req_ready, 4'b0100);
        nx();
        oc_req_valid = '0;
        chk("mid_ret_valid", rd_valid, 1);
        chk("mid_ret_row", rd_row, 7);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_ocid", rd_ocid, 0);
        chk("mid_rst_row", rd_row, 0);
        chk("mid_rst_en", rf_en, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wb_valid     = 1'b1;
        wb_row       = 3'd6;
        wb_data      = {32{8'hD6}};
        oc_req_valid = 4'hF;
        oc_req_row   = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("post_wb_%0d", k), wb_ready, 1);
            nx();
        end
        smp();
        chk("post_rr_ptr", oc_req_ready, 4'b0001);
        chk("post_wb_block", wb_ready, 0);
        nx();
        wb_valid     = 1'b0;
        oc_req_valid = '0;
        smp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
